// File: rtl/irig_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : irig_pulse_decoder
//  Description : IRIG-B front end. Synchronizes the raw DC level-shift input,
//                measures each high pulse and classifies it as logic 0,
//                logic 1 or position mark. Flags illegal widths and carrier
//                loss, and strobes every armed rising edge (on-time point).
//  Revision    : 1.0 - initial release
// ============================================================================
module irig_pulse_decoder #(
  parameter int TH_MIN     = 10000,
  parameter int TH_01      = 35000,
  parameter int TH_1M      = 65000,
  parameter int TH_MAX     = 90000,
  parameter int TH_TIMEOUT = 150000
) (
  input  logic clk,
  input  logic rst,
  input  logic irig_in,
  output logic irig_d0,
  output logic irig_d1,
  output logic irig_mark,
  output logic irig_err,
  output logic irig_rise
);

  localparam int CNT_W = $clog2(TH_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] c_th_min     = CNT_W'(TH_MIN);
  localparam logic [CNT_W-1:0] c_th_01      = CNT_W'(TH_01);
  localparam logic [CNT_W-1:0] c_th_1m      = CNT_W'(TH_1M);
  localparam logic [CNT_W-1:0] c_th_max     = CNT_W'(TH_MAX);
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TH_TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_timeout;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_edge    = w_rise | w_fall;
  // The count only ever reaches TH_TIMEOUT-1 once per edge-free interval,
  // because it then parks at TH_TIMEOUT until the next edge.
  assign w_timeout = ~w_edge & (r_cnt == c_timeout_m1);

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= irig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Cycles since the last edge; equals the high width when a fall is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= c_one;
    end else if (r_cnt != c_timeout) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // The first fall after reset only arms, discarding a possibly partial pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (w_fall) begin
      r_armed <= 1'b1;
    end
  end

  // Registered single-cycle strobes: width classification, rise and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      irig_d0   <= 1'b0;
      irig_d1   <= 1'b0;
      irig_mark <= 1'b0;
      irig_err  <= 1'b0;
      irig_rise <= 1'b0;
    end else begin
      irig_d0   <= 1'b0;
      irig_d1   <= 1'b0;
      irig_mark <= 1'b0;
      irig_err  <= w_timeout;
      irig_rise <= w_rise & r_armed;
      if (w_fall && r_armed) begin
        if (r_cnt < c_th_min) begin
          irig_err <= 1'b1;
        end else if (r_cnt < c_th_01) begin
          irig_d0 <= 1'b1;
        end else if (r_cnt < c_th_1m) begin
          irig_d1 <= 1'b1;
        end else if (r_cnt <= c_th_max) begin
          irig_mark <= 1'b1;
        end else begin
          irig_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irig_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irig_pulse_decoder
//  Description : Self-checking bench for irig_pulse_decoder. An event model
//                predicts strobes from input edges; a width table and a few
//                hand sequences check the corner cases explicitly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irig_pulse_decoder;

  localparam int TMIN = 10;
  localparam int T01  = 35;
  localparam int T1M  = 65;
  localparam int TMAX = 90;
  localparam int TTO  = 150;

  // Strobe vector layout: {rise, err, mark, d1, d0}
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_D0   = 5'b00001;
  localparam logic [4:0] EV_D1   = 5'b00010;
  localparam logic [4:0] EV_MK   = 5'b00100;
  localparam logic [4:0] EV_ER   = 5'b01000;
  localparam logic [4:0] EV_RS   = 5'b10000;
  localparam logic [4:0] EV_ALL  = 5'b11111;

  typedef struct {
    int         width;
    logic [4:0] cls;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irig_in = 1'b0;
  logic irig_d0, irig_d1, irig_mark, irig_err, irig_rise;

  irig_pulse_decoder #(
    .TH_MIN    (TMIN),
    .TH_01     (T01),
    .TH_1M     (T1M),
    .TH_MAX    (TMAX),
    .TH_TIMEOUT(TTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irig_in  (irig_in),
    .irig_d0  (irig_d0),
    .irig_d1  (irig_d1),
    .irig_mark(irig_mark),
    .irig_err (irig_err),
    .irig_rise(irig_rise)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;             // negedge index of the current step

  logic [4:0] exp_ev  [int];    // expected strobes keyed by negedge index
  logic [4:0] act_log [int];    // observed strobes keyed by negedge index

  // Reference model state: edges of the driven waveform, not DUT internals
  bit m_in_reset = 1'b1;
  bit m_level    = 1'b0;
  bit m_armed    = 1'b0;
  int m_start    = 0;           // index where the edge-free interval began
  int m_rise_n   = 0;

  function automatic logic [4:0] classify(int w);
    if (w < TMIN)  return EV_ER;
    if (w < T01)   return EV_D0;
    if (w < T1M)   return EV_D1;
    if (w <= TMAX) return EV_MK;
    return EV_ER;
  endfunction

  function automatic void schedule(int at, logic [4:0] ev);
    if (exp_ev.exists(at)) exp_ev[at] = exp_ev[at] | ev;
    else                   exp_ev[at] = ev;
  endfunction

  // An input change applied at index n shows up as a strobe at index n+3.
  // A quiet interval starting at index s times out with a strobe at s+152
  // unless an edge arrives by index s+149.
  function automatic void model_update(logic lvl, logic r);
    if (r) begin
      for (int k = 1; k <= 3; k++) exp_ev.delete(n + k);
      m_in_reset = 1'b1;
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_armed    = 1'b0;
      m_level    = lvl;
      m_start    = n - 2;
      if (lvl) begin
        m_rise_n = n;
        m_start  = n;
      end
    end else if (lvl != m_level) begin
      m_level = lvl;
      if (lvl) begin
        if (m_armed) schedule(n + 3, EV_RS);
        m_rise_n = n;
      end else begin
        if (m_armed) schedule(n + 3, classify(n - m_rise_n));
        else         m_armed = 1'b1;
      end
      m_start = n;
    end else if (n - m_start == TTO - 1) begin
      schedule(n + 3, EV_ER);
    end
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, required %b (rise,err,mark,d1,d0)", name, act, req);
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic int count_ev(int from, int to, logic [4:0] mask);
    int c = 0;
    for (int k = from; k <= to; k++)
      if (act_log.exists(k) && ((act_log[k] & mask) != 5'b0)) c++;
    return c;
  endfunction

  // One clock: sample and compare outputs, then apply the next input/reset
  task automatic step(input logic lvl, input logic r);
    logic [4:0] act;
    logic [4:0] req;
    @(negedge clk);
    n++;
    act = {irig_rise, irig_err, irig_mark, irig_d1, irig_d0};
    act_log[n] = act;
    req = exp_ev.exists(n) ? exp_ev[n] : EV_NONE;
    chk($sformatf("model cycle %0d", n), act, req);
    rst     = r;
    irig_in = lvl;
    model_update(lvl, r);
  endtask

  task automatic drive(input logic lvl, input int cycles);
    repeat (cycles) step(lvl, 1'b0);
  endtask

  initial begin
    vec_t tbl [11];
    int rn, fn, r2, f2, s0;

    tbl[0]  = '{20, EV_D0};
    tbl[1]  = '{50, EV_D1};
    tbl[2]  = '{80, EV_MK};
    tbl[3]  = '{9,  EV_ER};
    tbl[4]  = '{10, EV_D0};
    tbl[5]  = '{34, EV_D0};
    tbl[6]  = '{35, EV_D1};
    tbl[7]  = '{64, EV_D1};
    tbl[8]  = '{65, EV_MK};
    tbl[9]  = '{90, EV_MK};
    tbl[10] = '{91, EV_ER};

    repeat (3) @(posedge clk);
    repeat (4) step(1'b0, 1'b1);

    // Reset then pulse train: the first pulse only arms
    drive(1'b0, 10);
    s0 = n + 1;
    drive(1'b1, 50);
    drive(1'b0, 30);
    chk_int("first pulse silent", count_ev(s0, n, EV_ALL), 0);

    // Width table, including the classification boundaries
    foreach (tbl[i]) begin
      rn = n + 1;
      drive(1'b1, tbl[i].width);
      fn = n + 1;
      drive(1'b0, 30);
      chk($sformatf("rise w=%0d", tbl[i].width), act_log[rn + 3], EV_RS);
      chk($sformatf("class w=%0d", tbl[i].width), act_log[fn + 3], tbl[i].cls);
    end

    // Stuck low after an armed mark
    drive(1'b1, 80);
    fn = n + 1;
    drive(1'b0, 400);
    chk("stuck low mark", act_log[fn + 3], EV_MK);
    chk("stuck low timeout", act_log[fn + 152], EV_ER);
    chk_int("stuck low strobe count", count_ev(fn + 4, n, EV_ALL), 1);

    // Stuck high: timeout err, then err at the fall
    rn = n + 1;
    drive(1'b1, 300);
    fn = n + 1;
    drive(1'b0, 30);
    chk("stuck high timeout", act_log[rn + 152], EV_ER);
    chk("stuck high fall", act_log[fn + 3], EV_ER);
    chk_int("stuck high no data", count_ev(rn, n, EV_D0 | EV_D1 | EV_MK), 0);
    chk_int("stuck high err count", count_ev(rn, n, EV_ER), 2);

    // Reset 40 cycles into a 50-cycle high
    rn = n + 1;
    drive(1'b1, 40);
    repeat (3) step(1'b1, 1'b1);
    drive(1'b1, 7);
    drive(1'b0, 30);
    r2 = n + 1;
    drive(1'b1, 20);
    f2 = n + 1;
    drive(1'b0, 30);
    chk_int("reset mid-pulse silent", count_ev(rn + 41, r2 + 2, EV_ALL), 0);
    chk("post-reset rise", act_log[r2 + 3], EV_RS);
    chk("post-reset d0", act_log[f2 + 3], EV_D0);

    // Latency of a single 50-cycle pulse
    drive(1'b1, 50);
    fn = n + 1;
    drive(1'b0, 30);
    chk("latency early", act_log[fn + 2], EV_NONE);
    chk("latency d1", act_log[fn + 3], EV_D1);
    chk("latency single cycle", act_log[fn + 4], EV_NONE);

    // Randomized pulse trains with occasional long gaps and resets
    for (int i = 0; i < 250; i++) begin
      int hw;
      int lw;
      hw = (i % 10 == 0) ? int'($urandom_range(91, 200)) : int'($urandom_range(2, 95));
      lw = (i % 17 == 0) ? int'($urandom_range(150, 220)) : int'($urandom_range(2, 100));
      drive(1'b1, hw);
      drive(1'b0, lw);
      if (i % 40 == 25) begin
        repeat (int'($urandom_range(1, 4))) step(1'($urandom_range(0, 1)), 1'b1);
      end
    end
    drive(1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
